// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per RUN cycle, MSB first.
// A zero divisor bypasses RUN and reports all-ones quotient with dbz set.
module div32_seq #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         dbz
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [N-1:0]   a;
    logic [N-1:0]   d;
    logic [N-1:0]   r;
    logic [N-1:0]   q;
    logic [CW-1:0]  cnt;
    logic           zpend;

    logic [N:0]     sh;
    logic [N+1:0]   sum;
    logic           nb;
    logic [N-1:0]   rnext;
    logic [N-1:0]   qnext;

    // Carry-out of R + ~D + 1 is set exactly when the shifted remainder >= D.
    always_comb begin
        sh    = {r, a[N-1]};
        sum   = {1'b0, sh} + {1'b0, ~{1'b0, d}} + (N+2)'(1);
        nb    = sum[N+1];
        rnext = nb ? sum[N-1:0] : sh[N-1:0];
        qnext = {q[N-2:0], nb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            d     <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            zpend <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // A zero-divisor start spends one cycle here before reporting.
                    if (zpend) begin
                        zpend <= 1'b0;
                        state <= DONE;
                        done  <= 1'b1;
                        quot  <= '1;
                        rem   <= a;
                        dbz   <= 1'b1;
                    end else if (start) begin
                        a   <= i0;
                        d   <= i1;
                        r   <= '0;
                        q   <= '0;
                        cnt <= '0;
                        dbz <= 1'b0;
                        if (i1 != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            zpend <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a   <= a << 1;
                    r   <= rnext;
                    q   <= qnext;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        quot  <= qnext;
                        rem   <= rnext;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Randomized self-checking bench for div32_seq against a plain-arithmetic
// division model, plus directed corner scenarios.
module tb_div32_seq;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  i0;
    logic [N-1:0]  i1;
    logic          busy;
    logic          done;
    logic [N-1:0]  quot;
    logic [N-1:0]  rem;
    logic          dbz;

    int tests = 0;
    int fails = 0;

    div32_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .i0    (i0),
        .i1    (i1),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; that edge is E0.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        i0    = a;
        i1    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in the cycle after E0; returns in the done cycle (or after timeout).
    task automatic wait_done(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input int inject_c);
        int c = 0;
        int bc = 0;
        bit seen = 0;
        logic [N-1:0] eq, er;
        int lat;
        eq  = (b == 0) ? {N{1'b1}} : a / b;
        er  = (b == 0) ? a : a % b;
        lat = (b == 0) ? 1 : N;
        while (c <= N + 8) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            if (c == inject_c) begin
                start = 1'b1;
                i0    = 1;
                i1    = 1;
            end else begin
                start = 1'b0;
                i0    = $urandom;
                i1    = $urandom;
            end
            tick();
            c++;
        end
        start = 1'b0;
        check({tag, "_latency"}, seen ? 64'(c) : 64'hdead, 64'(lat));
        check({tag, "_busycyc"}, 64'(bc), (b == 0) ? 64'd0 : 64'(N));
        check({tag, "_quot"}, 64'(quot), 64'(eq));
        check({tag, "_rem"}, 64'(rem), 64'(er));
        check({tag, "_dbz"}, 64'(dbz), (b == 0) ? 64'd1 : 64'd0);
    endtask

    // One cycle past done: pulse must be gone and results held.
    task automatic idle_check(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        start = 1'b0;
        tick();
        check({tag, "_donepulse"}, 64'(done), 64'd0);
        check({tag, "_busyidle"}, 64'(busy), 64'd0);
        check({tag, "_quothold"}, 64'(quot), (b == 0) ? 64'(32'hFFFF_FFFF) : 64'(a / b));
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return N'($urandom_range(0, 15));
            3:       return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcount;
        logic [N-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        i0    = '0;
        i1    = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_quot", 64'(quot), 0);
        check("rst_rem", 64'(rem), 0);
        check("rst_dbz", 64'(dbz), 0);
        rst = 1'b0;
        tick();

        start_op(100, 7);
        wait_done("d100_7", 100, 7, -1);
        idle_check("d100_7", 100, 7);

        start_op(32'hFFFF_FFFF, 1);
        wait_done("ones_1", 32'hFFFF_FFFF, 1, -1);
        idle_check("ones_1", 32'hFFFF_FFFF, 1);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("ones_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        idle_check("ones_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        start_op(5, 9);
        wait_done("small", 5, 9, -1);
        idle_check("small", 5, 9);
        start_op(1234, 0);
        wait_done("dbz", 1234, 0, -1);
        idle_check("dbz", 1234, 0);

        // Start during RUN ignored, then restart from the DONE cycle.
        start_op(100, 7);
        wait_done("ignore", 100, 7, 4);
        start_op(9, 3);
        wait_done("chain", 9, 3, -1);
        idle_check("chain", 9, 3);

        // Reset mid-run at E10.
        start_op(100, 7);
        for (int k = 0; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 0);
        check("midrst_done", 64'(done), 0);
        check("midrst_quot", 64'(quot), 0);
        check("midrst_rem", 64'(rem), 0);
        check("midrst_dbz", 64'(dbz), 0);
        dcount = 0;
        for (int k = 0; k < N + 8; k++) begin
            if (done) dcount++;
            tick();
        end
        check("midrst_nodone", 64'(dcount), 0);
        start_op(50, 6);
        wait_done("after_rst", 50, 6, -1);
        idle_check("after_rst", 50, 6);

        for (int k = 0; k < 1000; k++) begin
            ra = pick();
            rb = pick();
            start_op(ra, rb);
            wait_done("rand", ra, rb, -1);
            if ($urandom_range(0, 1) == 0) idle_check("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
